// File: rtl/ac97_cmd_arbiter.sv
// ac97_cmd_arbiter: round-robin owner of the AC-link command slots (out slots 1/2).
// One codec register access per frame; read data or a timeout is returned to the
// requester that issued the read.
module ac97_cmd_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_FRAMES = 4
) (
    input  logic                    ac97_bitclk,
    input  logic                    reset_b,
    input  logic                    ac97_strobe,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [7*NUM_REQ-1:0]    req_addr,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [15:0]             rsp_data,
    output logic                    rsp_timeout,
    input  logic                    ac97_in_slot1_valid,
    input  logic [19:0]             ac97_in_slot1,
    input  logic [19:0]             ac97_in_slot2,
    output logic [19:0]             ac97_out_slot1,
    output logic                    ac97_out_slot1_valid,
    output logic [19:0]             ac97_out_slot2,
    output logic                    ac97_out_slot2_valid,
    output logic                    busy
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_FRAMES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;

    // Registered state; the round-robin pointer doubles as the transaction owner
    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               cmd_write_q, cmd_write_d;
    logic [6:0]         cmd_addr_q, cmd_addr_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
    logic [15:0]        rsp_data_d;
    logic               rsp_timeout_d;
    logic [19:0]        slot1_d, slot2_d;
    logic               slot1_valid_d, slot2_valid_d;
    logic               busy_d;

    // Arbitration result
    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_write;
    logic [6:0]         arb_addr;
    logic [15:0]        arb_wdata;

    logic               rsp_match;
    logic               grant_ok;
    logic [7:0]         cnt_inc;

    // Only the register index and data fields of the inbound slots are used
    logic               unused_in_bits;
    assign unused_in_bits = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

    // Round-robin winner: first pending request after the pointer, with wrap
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!arb_found && req_valid[i] && (i == (32'(ptr_q) + k) % NUM_REQ)) begin
                    arb_found = 1'b1;
                    arb_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Select the winner's command fields
    always_comb begin
        arb_write = 1'b0;
        arb_addr  = '0;
        arb_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == arb_idx) begin
                arb_write = req_write[i];
                arb_addr  = req_addr[7*i +: 7];
                arb_wdata = req_wdata[16*i +: 16];
            end
        end
    end

    // Next-state and registered-output logic; everything advances only on strobe
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cmd_write_d   = cmd_write_q;
        cmd_addr_d    = cmd_addr_q;
        cnt_d         = cnt_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data;
        rsp_timeout_d = 1'b0;
        slot1_d       = ac97_out_slot1;
        slot1_valid_d = ac97_out_slot1_valid;
        slot2_d       = ac97_out_slot2;
        slot2_valid_d = ac97_out_slot2_valid;
        grant_ok      = 1'b0;
        cnt_inc       = cnt_q + 8'd1;
        rsp_match     = ac97_in_slot1_valid && (ac97_in_slot1[18:12] == cmd_addr_q);

        if (ac97_strobe) begin
            case (state_q)
                ST_IDLE: begin
                    grant_ok = 1'b1;
                end
                ST_CMD: begin
                    slot1_d       = '0;
                    slot1_valid_d = 1'b0;
                    slot2_d       = '0;
                    slot2_valid_d = 1'b0;
                    if (cmd_write_q) begin
                        state_d  = ST_IDLE;
                        grant_ok = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RD;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_RD: begin
                    if (rsp_match || (cnt_inc == TO_LAST)) begin
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            rsp_valid_d[i] = (IDX_W'(i) == ptr_q);
                        end
                        rsp_data_d    = rsp_match ? ac97_in_slot2[19:4] : 16'hFFFF;
                        rsp_timeout_d = !rsp_match;
                        state_d       = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (grant_ok && arb_found) begin
                state_d       = ST_CMD;
                ptr_d         = arb_idx;
                cmd_write_d   = arb_write;
                cmd_addr_d    = arb_addr;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready_d[i] = (IDX_W'(i) == arb_idx);
                end
                slot1_d       = {~arb_write, arb_addr, 12'h000};
                slot1_valid_d = 1'b1;
                slot2_d       = arb_write ? {arb_wdata, 4'h0} : 20'h00000;
                slot2_valid_d = arb_write;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b) begin
            state_q              <= ST_IDLE;
            ptr_q                <= IDX_W'(NUM_REQ - 1);
            cmd_write_q          <= 1'b0;
            cmd_addr_q           <= '0;
            cnt_q                <= '0;
            req_ready            <= '0;
            rsp_valid            <= '0;
            rsp_data             <= '0;
            rsp_timeout          <= 1'b0;
            ac97_out_slot1       <= '0;
            ac97_out_slot1_valid <= 1'b0;
            ac97_out_slot2       <= '0;
            ac97_out_slot2_valid <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            state_q              <= state_d;
            ptr_q                <= ptr_d;
            cmd_write_q          <= cmd_write_d;
            cmd_addr_q           <= cmd_addr_d;
            cnt_q                <= cnt_d;
            req_ready            <= req_ready_d;
            rsp_valid            <= rsp_valid_d;
            rsp_data             <= rsp_data_d;
            rsp_timeout          <= rsp_timeout_d;
            ac97_out_slot1       <= slot1_d;
            ac97_out_slot1_valid <= slot1_valid_d;
            ac97_out_slot2       <= slot2_d;
            ac97_out_slot2_valid <= slot2_valid_d;
            busy                 <= busy_d;
        end
    end

endmodule

// File: tb/tb_ac97_cmd_arbiter.sv
// tb_ac97_cmd_arbiter: frame-level vector table for ac97_cmd_arbiter plus a
// hand-written async-reset-during-read sequence.
module tb_ac97_cmd_arbiter;

    localparam int unsigned NUM_REQ        = 3;
    localparam int unsigned TIMEOUT_FRAMES = 4;

    logic                  ac97_bitclk = 1'b0;
    logic                  reset_b;
    logic                  ac97_strobe;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [7*NUM_REQ-1:0]  req_addr;
    logic [16*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [15:0]           rsp_data;
    logic                  rsp_timeout;
    logic                  ac97_in_slot1_valid;
    logic [19:0]           ac97_in_slot1;
    logic [19:0]           ac97_in_slot2;
    logic [19:0]           ac97_out_slot1;
    logic                  ac97_out_slot1_valid;
    logic [19:0]           ac97_out_slot2;
    logic                  ac97_out_slot2_valid;
    logic                  busy;

    ac97_cmd_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) dut (
        .ac97_bitclk          (ac97_bitclk),
        .reset_b              (reset_b),
        .ac97_strobe          (ac97_strobe),
        .req_valid            (req_valid),
        .req_write            (req_write),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .req_ready            (req_ready),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .rsp_timeout          (rsp_timeout),
        .ac97_in_slot1_valid  (ac97_in_slot1_valid),
        .ac97_in_slot1        (ac97_in_slot1),
        .ac97_in_slot2        (ac97_in_slot2),
        .ac97_out_slot1       (ac97_out_slot1),
        .ac97_out_slot1_valid (ac97_out_slot1_valid),
        .ac97_out_slot2       (ac97_out_slot2),
        .ac97_out_slot2_valid (ac97_out_slot2_valid),
        .busy                 (busy)
    );

    always #5 ac97_bitclk = ~ac97_bitclk;

    // One record per frame strobe: inputs before the strobe, outputs after it
    typedef struct packed {
        logic        rst;
        logic [2:0]  valid;
        logic [2:0]  write;
        logic [20:0] addr;
        logic [47:0] wdata;
        logic        in_v;
        logic [19:0] in_s1;
        logic [19:0] in_s2;
        logic [2:0]  e_ready;
        logic [2:0]  e_rsp;
        logic [15:0] e_data;
        logic        e_to;
        logic [19:0] e_s1;
        logic        e_s1v;
        logic [19:0] e_s2;
        logic        e_s2v;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_b     = 1'b0;
        ac97_strobe = 1'b0;
        repeat (2) @(posedge ac97_bitclk);
        #1;
        reset_b = 1'b1;
    endtask

    task automatic strobe_edge();
        @(negedge ac97_bitclk);
        ac97_strobe = 1'b1;
        @(posedge ac97_bitclk);
        #1;
        ac97_strobe = 1'b0;
    endtask

    task automatic check_all(input string pfx, input vec_t v);
        chk({pfx, " req_ready"},   32'(req_ready),            32'(v.e_ready));
        chk({pfx, " rsp_valid"},   32'(rsp_valid),            32'(v.e_rsp));
        chk({pfx, " rsp_data"},    32'(rsp_data),             32'(v.e_data));
        chk({pfx, " rsp_timeout"}, 32'(rsp_timeout),          32'(v.e_to));
        chk({pfx, " slot1"},       32'(ac97_out_slot1),       32'(v.e_s1));
        chk({pfx, " slot1_valid"}, 32'(ac97_out_slot1_valid), 32'(v.e_s1v));
        chk({pfx, " slot2"},       32'(ac97_out_slot2),       32'(v.e_s2));
        chk({pfx, " slot2_valid"}, 32'(ac97_out_slot2_valid), 32'(v.e_s2v));
        chk({pfx, " busy"},        32'(busy),                 32'(v.e_busy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        string pfx;

        // rst valid  write  addr                         wdata                               in_v in_s1     in_s2     ready  rsp    data      to    s1        s1v   s2        s2v   busy
        // Single write after reset
        vecs.push_back(vec_t'{1'b0, 3'b001, 3'b001, {7'h00,7'h00,7'h02}, {16'h0000,16'h0000,16'h0000}, 1'b0, 20'h0, 20'h0, 3'b001, 3'b000, 16'h0000, 1'b0, 20'h02000, 1'b1, 20'h00000, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b0, 20'h0, 20'h0, 3'b000, 3'b000, 16'h0000, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0});
        // Fresh reset: req0 and req2 hold writes -> 0 then 2, then all three rotate 0,1,2,0
        vecs.push_back(vec_t'{1'b1, 3'b101, 3'b101, {7'h11,7'h00,7'h10}, {16'hBEEF,16'h0000,16'h1234}, 1'b0, 20'h0, 20'h0, 3'b001, 3'b000, 16'h0000, 1'b0, 20'h10000, 1'b1, 20'h12340, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b101, 3'b101, {7'h11,7'h00,7'h10}, {16'hBEEF,16'h0000,16'h1234}, 1'b0, 20'h0, 20'h0, 3'b100, 3'b000, 16'h0000, 1'b0, 20'h11000, 1'b1, 20'hBEEF0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b111, 3'b111, {7'h11,7'h12,7'h10}, {16'hBEEF,16'h5678,16'h1234}, 1'b0, 20'h0, 20'h0, 3'b001, 3'b000, 16'h0000, 1'b0, 20'h10000, 1'b1, 20'h12340, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b111, 3'b111, {7'h11,7'h12,7'h10}, {16'hBEEF,16'h5678,16'h1234}, 1'b0, 20'h0, 20'h0, 3'b010, 3'b000, 16'h0000, 1'b0, 20'h12000, 1'b1, 20'h56780, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b111, 3'b111, {7'h11,7'h12,7'h10}, {16'hBEEF,16'h5678,16'h1234}, 1'b0, 20'h0, 20'h0, 3'b100, 3'b000, 16'h0000, 1'b0, 20'h11000, 1'b1, 20'hBEEF0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b111, 3'b111, {7'h11,7'h12,7'h10}, {16'hBEEF,16'h5678,16'h1234}, 1'b0, 20'h0, 20'h0, 3'b001, 3'b000, 16'h0000, 1'b0, 20'h10000, 1'b1, 20'h12340, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b0, 20'h0, 20'h0, 3'b000, 3'b000, 16'h0000, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0});
        // req1 reads 7'h26; a matching reply during the command frame is ignored, the next one completes
        vecs.push_back(vec_t'{1'b0, 3'b010, 3'b000, {7'h00,7'h26,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b0, 20'h0, 20'h0, 3'b010, 3'b000, 16'h0000, 1'b0, 20'hA6000, 1'b1, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b1, 20'h26000, 20'hDEAD0, 3'b000, 3'b000, 16'h0000, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b1, 20'h26000, 20'h000F0, 3'b000, 3'b010, 16'h000F, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0});
        // req0 reads 7'h7C; only wrong-address or untagged replies -> timeout after 4 frames
        vecs.push_back(vec_t'{1'b0, 3'b001, 3'b000, {7'h00,7'h00,7'h7C}, {16'h0000,16'h0000,16'h0000}, 1'b0, 20'h0, 20'h0, 3'b001, 3'b000, 16'h000F, 1'b0, 20'hFC000, 1'b1, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b1, 20'h7E000, 20'h12340, 3'b000, 3'b000, 16'h000F, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b0, 20'h7C000, 20'h12340, 3'b000, 3'b000, 16'h000F, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b1, 20'h7E000, 20'h12340, 3'b000, 3'b000, 16'h000F, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b1, 20'h7E000, 20'h12340, 3'b000, 3'b000, 16'h000F, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b1, 20'h7E000, 20'h12340, 3'b000, 3'b001, 16'hFFFF, 1'b1, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0});
        // req2 read in flight while req0 asks for a write: write waits until the strobe after completion
        vecs.push_back(vec_t'{1'b0, 3'b100, 3'b000, {7'h05,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b0, 20'h0, 20'h0, 3'b100, 3'b000, 16'hFFFF, 1'b0, 20'h85000, 1'b1, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b001, 3'b001, {7'h00,7'h00,7'h33}, {16'h0000,16'h0000,16'hABCD}, 1'b0, 20'h0, 20'h0, 3'b000, 3'b000, 16'hFFFF, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b001, 3'b001, {7'h00,7'h00,7'h33}, {16'h0000,16'h0000,16'hABCD}, 1'b1, 20'h05000, 20'h55550, 3'b000, 3'b100, 16'h5555, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 3'b001, 3'b001, {7'h00,7'h00,7'h33}, {16'h0000,16'h0000,16'hABCD}, 1'b0, 20'h0, 20'h0, 3'b001, 3'b000, 16'h5555, 1'b0, 20'h33000, 1'b1, 20'hABCD0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 3'b000, 3'b000, {7'h00,7'h00,7'h00}, {16'h0000,16'h0000,16'h0000}, 1'b0, 20'h0, 20'h0, 3'b000, 3'b000, 16'h5555, 1'b0, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0});

        reset_b             = 1'b1;
        ac97_strobe         = 1'b0;
        req_valid           = '0;
        req_write           = '0;
        req_addr            = '0;
        req_wdata           = '0;
        ac97_in_slot1_valid = 1'b0;
        ac97_in_slot1       = '0;
        ac97_in_slot2       = '0;

        do_reset();
        v = '0;
        check_all("reset", v);

        foreach (vecs[i]) begin
            v = vecs[i];
            pfx = $sformatf("v%0d", i);
            if (v.rst) do_reset();
            req_valid           = v.valid;
            req_write           = v.write;
            req_addr            = v.addr;
            req_wdata           = v.wdata;
            ac97_in_slot1_valid = v.in_v;
            ac97_in_slot1       = v.in_s1;
            ac97_in_slot2       = v.in_s2;
            strobe_edge();
            check_all(pfx, v);
            // Pulses last one cycle; slots and busy hold for the frame
            @(posedge ac97_bitclk);
            #1;
            chk({pfx, " +1 req_ready"},   32'(req_ready),      32'h0);
            chk({pfx, " +1 rsp_valid"},   32'(rsp_valid),      32'h0);
            chk({pfx, " +1 rsp_timeout"}, 32'(rsp_timeout),    32'h0);
            chk({pfx, " +1 slot1"},       32'(ac97_out_slot1), 32'(v.e_s1));
            chk({pfx, " +1 busy"},        32'(busy),           32'(v.e_busy));
            repeat (2) @(posedge ac97_bitclk);
            #1;
        end

        // Async reset while req1's read is waiting for its reply
        req_valid = 3'b010;
        req_write = 3'b000;
        req_addr  = {7'h00, 7'h20, 7'h00};
        req_wdata = '0;
        ac97_in_slot1_valid = 1'b0;
        strobe_edge();
        chk("rst_rd grant",   32'(req_ready),      32'h2);
        chk("rst_rd slot1",   32'(ac97_out_slot1), 32'hA0000);
        req_valid = 3'b000;
        strobe_edge();
        chk("rst_rd wait busy", 32'(busy), 32'h1);
        @(posedge ac97_bitclk);
        #3;
        reset_b = 1'b0;
        #1;
        chk("rst_rd busy",        32'(busy),                 32'h0);
        chk("rst_rd rsp_data",    32'(rsp_data),             32'h0);
        chk("rst_rd rsp_valid",   32'(rsp_valid),            32'h0);
        chk("rst_rd slot1_valid", 32'(ac97_out_slot1_valid), 32'h0);
        @(negedge ac97_bitclk);
        reset_b = 1'b1;
        repeat (2) @(posedge ac97_bitclk);
        #1;
        // The reply that would have matched must not produce a response; req0 wins first
        ac97_in_slot1_valid = 1'b1;
        ac97_in_slot1       = 20'h20000;
        ac97_in_slot2       = 20'h11110;
        req_valid = 3'b011;
        req_write = 3'b011;
        req_addr  = {7'h00, 7'h21, 7'h20};
        req_wdata = {16'h0000, 16'h2222, 16'h1111};
        strobe_edge();
        chk("post_rst req_ready", 32'(req_ready),      32'h1);
        chk("post_rst rsp_valid", 32'(rsp_valid),      32'h0);
        chk("post_rst slot1",     32'(ac97_out_slot1), 32'h20000);
        chk("post_rst slot2",     32'(ac97_out_slot2), 32'h11110);
        chk("post_rst busy",      32'(busy),           32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
